// File: rtl/decode_rob.sv
// In-order reorder buffer: hands out 4-bit ROB tags at decode and retires one entry per cycle in program order.
// Optional build macro DECODE_ROB_WB_BYPASS_EN lets a head writeback retire in the same cycle.
module decode_rob #(
    parameter int ENTRIES = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       alloc_valid,
    output logic       alloc_ready,
    input  logic [4:0] alloc_dst,
    input  logic [7:0] alloc_fid,
    output logic [3:0] alloc_rob,
    input  logic       wb_valid,
    input  logic [3:0] wb_rob,
    output logic       commit_valid,
    output logic [4:0] commit_dst,
    output logic [7:0] commit_fid,
    output logic [3:0] commit_rob,
    input  logic       snoop_hit,
    input  logic       bco_valid,
    output logic       empty
);

    localparam logic [4:0] FULL_CNT = 5'(ENTRIES);

    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [ENTRIES-1:0] done_q, done_d;
    logic [4:0]         dst_q [ENTRIES];
    logic [4:0]         dst_d [ENTRIES];
    logic [7:0]         fid_q [ENTRIES];
    logic [7:0]         fid_d [ENTRIES];
    logic [3:0]         head_q, head_d;
    logic [3:0]         tail_q, tail_d;
    logic [4:0]         count_q, count_d;
    logic               commit_valid_q, commit_valid_d;
    logic [4:0]         commit_dst_q, commit_dst_d;
    logic [7:0]         commit_fid_q, commit_fid_d;
    logic [3:0]         commit_rob_q, commit_rob_d;

    logic flush;
    logic alloc_fire;
    logic wb_hit;
    logic head_done;
    logic retire;

    assign alloc_ready = (count_q < FULL_CNT);
    assign alloc_rob   = tail_q;
    assign empty       = (count_q == 5'd0);

    assign commit_valid = commit_valid_q;
    assign commit_dst   = commit_dst_q;
    assign commit_fid   = commit_fid_q;
    assign commit_rob   = commit_rob_q;

    assign flush      = snoop_hit | bco_valid;
    assign alloc_fire = alloc_valid & alloc_ready;
    assign wb_hit     = wb_valid & valid_q[wb_rob];

`ifdef DECODE_ROB_WB_BYPASS_EN
    assign head_done = done_q[head_q] | (wb_hit & (wb_rob == head_q));
`else
    assign head_done = done_q[head_q];
`endif

    assign retire = valid_q[head_q] & head_done;

    // Retire clears the head slot before allocate writes tail; the two never alias
    // because allocation is blocked while all slots are occupied.
    always_comb begin
        valid_d        = valid_q;
        done_d         = done_q;
        dst_d          = dst_q;
        fid_d          = fid_q;
        head_d         = head_q;
        tail_d         = tail_q;
        count_d        = count_q;
        commit_valid_d = 1'b0;
        commit_dst_d   = commit_dst_q;
        commit_fid_d   = commit_fid_q;
        commit_rob_d   = commit_rob_q;

        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = 4'd0;
            tail_d  = 4'd0;
            count_d = 5'd0;
        end else begin
            if (wb_hit) begin
                done_d[wb_rob] = 1'b1;
            end
            if (retire) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 4'd1;
                commit_valid_d  = 1'b1;
                commit_dst_d    = dst_q[head_q];
                commit_fid_d    = fid_q[head_q];
                commit_rob_d    = head_q;
            end
            if (alloc_fire) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                dst_d[tail_q]   = alloc_dst;
                fid_d[tail_q]   = alloc_fid;
                tail_d          = tail_q + 4'd1;
            end
            count_d = count_q + 5'(alloc_fire) - 5'(retire);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q        <= '0;
            done_q         <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                dst_q[i] <= 5'd0;
                fid_q[i] <= 8'd0;
            end
            head_q         <= 4'd0;
            tail_q         <= 4'd0;
            count_q        <= 5'd0;
            commit_valid_q <= 1'b0;
            commit_dst_q   <= 5'd0;
            commit_fid_q   <= 8'd0;
            commit_rob_q   <= 4'd0;
        end else begin
            valid_q        <= valid_d;
            done_q         <= done_d;
            dst_q          <= dst_d;
            fid_q          <= fid_d;
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            commit_valid_q <= commit_valid_d;
            commit_dst_q   <= commit_dst_d;
            commit_fid_q   <= commit_fid_d;
            commit_rob_q   <= commit_rob_d;
        end
    end

endmodule

// File: tb/tb_decode_rob.sv
// Self-checking bench for decode_rob: directed vector table, hand-written corner sequences,
// then randomized traffic checked against a queue-based reorder-buffer model.
module tb_decode_rob;

`ifdef DECODE_ROB_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       resetn;
    logic       alloc_valid;
    logic       alloc_ready;
    logic [4:0] alloc_dst;
    logic [7:0] alloc_fid;
    logic [3:0] alloc_rob;
    logic       wb_valid;
    logic [3:0] wb_rob;
    logic       commit_valid;
    logic [4:0] commit_dst;
    logic [7:0] commit_fid;
    logic [3:0] commit_rob;
    logic       snoop_hit;
    logic       bco_valid;
    logic       empty;

    always #5 clk = ~clk;

    decode_rob #(.ENTRIES(16)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .alloc_valid  (alloc_valid),
        .alloc_ready  (alloc_ready),
        .alloc_dst    (alloc_dst),
        .alloc_fid    (alloc_fid),
        .alloc_rob    (alloc_rob),
        .wb_valid     (wb_valid),
        .wb_rob       (wb_rob),
        .commit_valid (commit_valid),
        .commit_dst   (commit_dst),
        .commit_fid   (commit_fid),
        .commit_rob   (commit_rob),
        .snoop_hit    (snoop_hit),
        .bco_valid    (bco_valid),
        .empty        (empty)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: program-ordered queue of in-flight instructions plus the head tag.
    typedef struct {
        logic [4:0] dst;
        logic [7:0] fid;
        bit         done;
    } ent_t;

    ent_t       mq[$];
    int         mhead;
    bit         exp_cv;
    logic [4:0] exp_dst;
    logic [7:0] exp_fid;
    logic [3:0] exp_rob;

    typedef struct {
        bit         av;
        logic [4:0] dst;
        logic [7:0] fid;
        bit         wv;
        logic [3:0] wr;
        logic [3:0] e_tag;
        bit         e_empty;
        bit         e_cv;
        logic [4:0] e_dst;
        logic [7:0] e_fid;
        logic [3:0] e_rob;
    } vec_t;

    vec_t tbl[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        mhead  = 0;
        exp_cv = 1'b0;
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, advance model, check registered outputs.
    task automatic applyStimulus(input bit av, input logic [4:0] dst, input logic [7:0] fid,
                                 input bit wv, input logic [3:0] wr, input bit snoop, input bit bco,
                                 output bit pre_ready, output logic [3:0] pre_tag, output bit pre_empty,
                                 output bit accepted);
        bit ret;
        alloc_valid = av;
        alloc_dst   = dst;
        alloc_fid   = fid;
        wb_valid    = wv;
        wb_rob      = wr;
        snoop_hit   = snoop;
        bco_valid   = bco;
        #1;
        pre_ready = alloc_ready;
        pre_tag   = alloc_rob;
        pre_empty = empty;
        checkOutput("alloc_ready", 32'(alloc_ready), 32'(mq.size() < 16));
        checkOutput("alloc_rob", 32'(alloc_rob), 32'((mhead + mq.size()) % 16));
        checkOutput("empty", 32'(empty), 32'(mq.size() == 0));

        accepted = 1'b0;
        if (snoop || bco) begin
            model_reset();
        end else begin
            accepted = av && (mq.size() < 16);
            ret = (mq.size() > 0) && (mq[0].done || (BYP && wv && (int'(wr) == mhead)));
            if (wv) begin
                for (int i = 0; i < mq.size(); i++) begin
                    if ((mhead + i) % 16 == int'(wr)) mq[i].done = 1'b1;
                end
            end
            exp_cv = ret;
            if (ret) begin
                exp_dst = mq[0].dst;
                exp_fid = mq[0].fid;
                exp_rob = 4'(mhead);
                void'(mq.pop_front());
                mhead = (mhead + 1) % 16;
            end
            if (accepted) mq.push_back('{dst: dst, fid: fid, done: 1'b0});
        end

        @(posedge clk);
        #1;
        checkOutput("commit_valid", 32'(commit_valid), 32'(exp_cv));
        if (exp_cv) begin
            checkOutput("commit_dst", 32'(commit_dst), 32'(exp_dst));
            checkOutput("commit_fid", 32'(commit_fid), 32'(exp_fid));
            checkOutput("commit_rob", 32'(commit_rob), 32'(exp_rob));
        end
    endtask

    function automatic vec_t mk(bit av, logic [4:0] dst, logic [7:0] fid, bit wv, logic [3:0] wr,
                                logic [3:0] tag, bit emp, bit cv, logic [4:0] cd, logic [7:0] cf,
                                logic [3:0] cr);
        vec_t v;
        v.av = av; v.dst = dst; v.fid = fid; v.wv = wv; v.wr = wr;
        v.e_tag = tag; v.e_empty = emp; v.e_cv = cv; v.e_dst = cd; v.e_fid = cf; v.e_rob = cr;
        return v;
    endfunction

    initial begin
        bit         rdy, emp, acc;
        logic [3:0] tag;
        int         wait_cycles;
        bit         got;

        resetn      = 1'b0;
        alloc_valid = 1'b0;
        alloc_dst   = 5'd0;
        alloc_fid   = 8'd0;
        wb_valid    = 1'b0;
        wb_rob      = 4'd0;
        snoop_hit   = 1'b0;
        bco_valid   = 1'b0;
        model_reset();

        #12;
        checkOutput("reset commit_valid", 32'(commit_valid), 32'd0);
        checkOutput("reset commit_dst", 32'(commit_dst), 32'd0);
        checkOutput("reset commit_fid", 32'(commit_fid), 32'd0);
        checkOutput("reset commit_rob", 32'(commit_rob), 32'd0);
        checkOutput("reset alloc_ready", 32'(alloc_ready), 32'd1);
        checkOutput("reset alloc_rob", 32'(alloc_rob), 32'd0);
        checkOutput("reset empty", 32'(empty), 32'd1);
        resetn = 1'b1;

        // Two allocations, out-of-order writebacks, then in-order commits.
        tbl.push_back(mk(1, 5'd5, 8'h11, 0, 4'd0, 4'd0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 5'd7, 8'h12, 0, 4'd0, 4'd1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 5'd0, 8'h00, 1, 4'd1, 4'd2, 0, 0, 0, 0, 0));
        if (BYP) begin
            tbl.push_back(mk(0, 0, 0, 1, 4'd0, 4'd2, 0, 1, 5'd5, 8'h11, 4'd0));
            tbl.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 1, 5'd7, 8'h12, 4'd1));
            tbl.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, 0, 0));
        end else begin
            tbl.push_back(mk(0, 0, 0, 1, 4'd0, 4'd2, 0, 0, 0, 0, 0));
            tbl.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 1, 5'd5, 8'h11, 4'd0));
            tbl.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 0, 1, 5'd7, 8'h12, 4'd1));
        end
        tbl.push_back(mk(0, 0, 0, 0, 4'd0, 4'd2, 1, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].av, tbl[i].dst, tbl[i].fid, tbl[i].wv, tbl[i].wr, 0, 0, rdy, tag, emp, acc);
            checkOutput($sformatf("vec%0d tag", i), 32'(tag), 32'(tbl[i].e_tag));
            checkOutput($sformatf("vec%0d empty", i), 32'(emp), 32'(tbl[i].e_empty));
            checkOutput($sformatf("vec%0d commit_valid", i), 32'(commit_valid), 32'(tbl[i].e_cv));
            if (tbl[i].e_cv) begin
                checkOutput($sformatf("vec%0d commit_dst", i), 32'(commit_dst), 32'(tbl[i].e_dst));
                checkOutput($sformatf("vec%0d commit_fid", i), 32'(commit_fid), 32'(tbl[i].e_fid));
                checkOutput($sformatf("vec%0d commit_rob", i), 32'(commit_rob), 32'(tbl[i].e_rob));
            end
        end

        // Writeback to unallocated tag 9 must not produce a commit.
        for (int i = 0; i < 3; i++) applyStimulus(1, 5'(i + 1), 8'(8'h20 + i), 0, 0, 0, 0, rdy, tag, emp, acc);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, (i == 0), 4'd9, 0, 0, rdy, tag, emp, acc);
            checkOutput("wb9 no commit", 32'(commit_valid), 32'd0);
        end

        // Five entries live, then branch-correction flush together with alloc and writeback.
        for (int i = 0; i < 2; i++) applyStimulus(1, 5'd3, 8'(8'h30 + i), 0, 0, 0, 0, rdy, tag, emp, acc);
        applyStimulus(1, 5'd4, 8'h40, 1, 4'd2, 0, 1, rdy, tag, emp, acc);
        checkOutput("flush empty", 32'(empty), 32'd1);
        checkOutput("flush alloc_rob", 32'(alloc_rob), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 4'(i + 2), 0, 0, rdy, tag, emp, acc);
            checkOutput("post-flush no commit", 32'(commit_valid), 32'd0);
        end
        applyStimulus(1, 5'd6, 8'h50, 0, 0, 0, 0, rdy, tag, emp, acc);
        checkOutput("post-flush first tag", 32'(tag), 32'd0);
        applyStimulus(0, 0, 0, 0, 0, 1, 0, rdy, tag, emp, acc);

        // Fill all 16 slots, then free the head while alloc_valid is held.
        for (int i = 0; i < 16; i++) applyStimulus(1, 5'(i), 8'(8'h60 + i), 0, 0, 0, 0, rdy, tag, emp, acc);
        checkOutput("full alloc_ready", 32'(alloc_ready), 32'd0);
        got = 1'b0;
        wait_cycles = 0;
        for (int i = 0; i < 6 && !got; i++) begin
            applyStimulus(1, 5'd9, 8'h99, (i == 0), 4'd0, 0, 0, rdy, tag, emp, acc);
            if (acc) begin
                got = 1'b1;
                wait_cycles = i;
                checkOutput("wrap tag", 32'(tag), 32'd0);
            end
        end
        checkOutput("full accept seen", 32'(got), 32'd1);
        checkOutput("full accept cycle", 32'(wait_cycles), BYP ? 32'd1 : 32'd2);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(($urandom_range(0, 99) < 60), 5'($urandom), 8'($urandom),
                          ($urandom_range(0, 99) < 70), 4'((mhead + $urandom_range(0, 17)) % 16),
                          ($urandom_range(0, 199) == 0), ($urandom_range(0, 199) == 0),
                          rdy, tag, emp, acc);
        end

        // Asynchronous reset mid-cycle must clear state without a clock edge.
        for (int i = 0; i < 4; i++) applyStimulus(1, 5'd1, 8'(i), 1, 4'(mhead), 0, 0, rdy, tag, emp, acc);
        #2;
        resetn = 1'b0;
        #1;
        checkOutput("async reset empty", 32'(empty), 32'd1);
        checkOutput("async reset alloc_rob", 32'(alloc_rob), 32'd0);
        checkOutput("async reset commit_valid", 32'(commit_valid), 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            applyStimulus(($urandom_range(0, 99) < 60), 5'($urandom), 8'($urandom),
                          ($urandom_range(0, 99) < 70), 4'((mhead + $urandom_range(0, 17)) % 16),
                          0, 0, rdy, tag, emp, acc);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_rob.md
# decode_rob

In-order reorder buffer that issues ROB tags at decode and retires entries in program order. It is the tag producer for the decode register alias table. Each allocation returns the 4-bit ROB index and the fetch ID that the RAT records for a destination register. Each retirement drives the RAT commit port (address, write enable, fetch ID) so the RAT can clear a mapping whose fetch ID still matches.

## Interface
- `ENTRIES`, default 16: number of ROB entries. Fixed at 16 to match the 4-bit ROB tag width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `alloc_valid`  in  1  decode requests one entry.
- `alloc_ready`  out  1  an entry is free: `count < 16`.
- `alloc_dst`  in  5  architectural destination register; 0 means no destination.
- `alloc_fid`  in  8  fetch ID of the instruction.
- `alloc_rob`  out  4  tag being allocated; equals `tail`, combinational.
- `wb_valid`  in  1  execution result written back.
- `wb_rob`  in  4  tag of the written-back entry.
- `commit_valid`  out  1  one-cycle retire pulse; drives RAT `wee`.
- `commit_dst`  out  5  retired destination; drives RAT `addre`.
- `commit_fid`  out  8  retired fetch ID; drives RAT `dine_fid`.
- `commit_rob`  out  4  retired tag.
- `snoop_hit`  in  1  flush all entries.
- `bco_valid`  in  1  branch-correction flush of all entries.
- `empty`  out  1  `count == 0`.

## Operation
- Per-entry state: `valid`, `done`, `dst[4:0]`, `fid[7:0]`.
- Pointers: `head[3:0]`, `tail[3:0]`, `count[4:0]`. The pointers wrap modulo 16 naturally.
- **Allocate.** The handshake is `alloc_valid && alloc_ready`.
  - Writes entry[`tail`] with valid=1, done=0, dst, fid.
  - `tail` increments by 1.
- **Writeback.** On `wb_valid`, if entry[`wb_rob`] is valid, set done=1. Writeback to an invalid entry is ignored.
- **Retire.** Retire when entry[`head`] is valid and done.
  - Registers `commit_valid`=1 with that entry's dst, fid and tag.
  - Clears entry[`head`].valid.
  - `head` increments by 1.
  - At most one retire per cycle.
  - An entry with dst=0 still retires and still pulses `commit_valid`. The RAT ignores address 0.
- **Count.** `count` += alloc − retire. Allocate and retire in the same cycle leave `count` unchanged.
- **Flush.** `snoop_hit` or `bco_valid` takes priority over allocate, writeback and retire.
  - Clears all valid/done bits and sets head=tail=count=0.
  - `commit_valid` is 0 the next cycle.
  - An allocate handshake in the flush cycle is dropped.

## Timing
- Reset values: `commit_valid`=0, `commit_dst`=0, `commit_fid`=0, `commit_rob`=0, head=tail=count=0, all entries invalid.
  - Consequently `alloc_ready`=1, `alloc_rob`=0 and `empty`=1 out of reset.
- `alloc_ready`, `alloc_rob` and `empty` are combinational from registered state. There is no input-to-output combinational path.
- `alloc_ready` depends on `count` only. When full, a retire in the same cycle does not admit an allocation; the allocation is accepted in the following cycle.
- Writeback in cycle N sets done at edge N. The head entry then retires at edge N+1, so `commit_valid` is high in cycle N+2 (without bypass).
- A writeback arriving in the allocation cycle of the same tag is ignored; the entry is not yet valid.
- Reset asserted mid-operation returns all state to reset values immediately, without waiting for a clock edge.

## Configuration
- `DECODE_ROB_WB_BYPASS_EN` defined:
  - A writeback to the current `head` (valid entry) qualifies that entry for retire in the same cycle.
  - `commit_valid` rises in cycle N+1.
  - done is still set for non-head entries.
- Not defined: retire uses only the registered done bit (latency N+2).
- Flush priority is identical in both builds.

## Test plan
- Reset, then allocate dst=5/fid=0x11 and dst=7/fid=0x12. Required: tags 0 and 1, count=2, `empty`=0, no commit.
- Writeback tag 1, then tag 0. Required: no commit after tag 1. After tag 0 at cycle N, commits in cycles N+2 and N+3 with (dst 5, fid 0x11, rob 0) then (dst 7, fid 0x12, rob 1).
- Fill 16 entries. Required: `alloc_ready`=0. Writeback tag 0 and hold `alloc_valid`; the 17th allocation is accepted only the cycle after retire, receiving tag 0 (wrap-around).
- 5 entries allocated, `bco_valid` pulsed together with `alloc_valid` and `wb_valid`. Required: count=0, `empty`=1, no commit afterward, and the next allocation gets tag 0.
- Writeback to an unallocated tag 9. Required: no state change, no commit.
- With `DECODE_ROB_WB_BYPASS_EN`: writeback head in cycle N. Required: `commit_valid` in N+1. Without the macro: N+2.
